load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle data-memory access stage. It sits downstream of the ALU and Main_Control_Unit and upstream of the Register_File write-back mux. It takes the ALU address, rs2 store data, Memread/Memwrite and funct3, and drives a ready/valid data-memory bus. It returns aligned, sign- or zero-extended load data, and holds `stall` high so Program_Counter freezes until the access completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed at 32; byte lanes = 4)
TIMEOUT_CYCLES, 16, cycles to wait for mem_ready before aborting (range 1..255)

Ports:
clk  input  1  clock; all state on the rising edge
reset  input  1  asynchronous, active-low; 0 = reset
memread  input  1  load request from Main_Control_Unit
memwrite  input  1  store request from Main_Control_Unit
funct3  input  3  RV32I width code: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010
addr  input  ADDR_W  effective address (ALU result)
store_data  input  DATA_W  rs2 value
stall  output  1  freezes PC/pipeline while high
load_data  output  DATA_W  formatted load result to write-back mux
load_valid  output  1  one-cycle strobe, load_data is valid
mem_err  output  1  one-cycle strobe: misaligned, illegal funct3, both read and write, or timeout
mem_req  output  1  bus request; held until mem_ready
mem_we  output  1  1 = write
mem_addr  output  ADDR_W  word-aligned address (addr with bits [1:0] = 0)
mem_wdata  output  DATA_W  lane-replicated store data
mem_be  output  4  byte enables
mem_ready  input  1  bus completion, may be asserted in the first request cycle
mem_rdata  input  DATA_W  read word, valid when mem_ready=1

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. Registered outputs mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, load_valid, mem_err all clear to 0. Timeout counter clears to 0. An access in flight is dropped; mem_req falls immediately.
- States: IDLE, ACCESS, DONE.
- IDLE, no request (memread=memwrite=0): stall=0, no action.
- IDLE, legal request:
  - stall=1, asserted combinationally the same cycle.
  - On the next edge: capture addr[1:0], funct3, op into internal registers; register mem_addr, mem_we, mem_be and mem_wdata; set mem_req=1; go to ACCESS.
- IDLE, illegal request: no bus cycle, stall=0, mem_err=1 for the next cycle, state stays IDLE. Illegal means any of:
  - memread and memwrite both 1
  - funct3 ∉ {000, 001, 010, 100, 101} for a load
  - funct3 ∉ {000, 001, 010} for a store
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]≠00
- Byte enables:
  - SB: 0001<<addr[1:0], mem_wdata = {4{store_data[7:0]}}
  - SH: 0011<<addr[1:0], mem_wdata = {2{store_data[15:0]}}
  - SW: 1111, mem_wdata = store_data
  - loads: 1111
- ACCESS:
  - stall=1; mem_req and all mem_* outputs held stable.
  - On an edge with mem_ready=1: mem_req clears. For a load, load_data is set to the lane selected by addr[1:0], sign-extended for LB/LH and zero-extended for LBU/LHU/LW. Go to DONE.
  - Each cycle without mem_ready increments the counter. When counter = TIMEOUT_CYCLES-1 with no ready: abort, mem_req clears, mem_err=1, load_data=0, go to DONE.
- DONE: stall=0, so PC advances at this edge. load_valid=1 only for a successful load. Next state is IDLE. The request inputs seen in DONE belong to the finished instruction and are ignored.
- Latency: a load with mem_ready in its first ACCESS cycle completes in 3 cycles (IDLE→ACCESS→DONE). stall is high for 2 of them.
- Counter is zeroed on every entry to ACCESS.

Decomposition:
- Shared package `lsu_pkg` holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum IDLE/ACCESS/DONE
  - function `be_mask(funct3, off)`
- Sub-module `load_align`: purely combinational mem_rdata + offset + funct3 → extended 32-bit value. It is instantiated once in the ACCESS→DONE capture path.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, mem_ready in first cycle → mem_addr=0x100, be=1111, stall high 2 cycles, then load_data=0xDEADBEEF with load_valid=1 in DONE.
- LB and LBU at addr=0x103, rdata=0x80112233 → load_data=0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH addr=0x202, store_data=0x1234ABCD → mem_we=1, mem_addr=0x200, be=1100, mem_wdata=0xABCDABCD, load_valid stays 0.
- LW addr=0x101 → no mem_req, mem_err pulse 1 cycle, stall=0 throughout, state IDLE.
- mem_ready held 0 with TIMEOUT_CYCLES=16 → mem_req high 16 cycles, then mem_err=1, load_data=0, DONE→IDLE.
- reset→0 in the 3rd ACCESS cycle → mem_req=0 and stall=0 without a clock edge. After release, a new SW to 0x40 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding and the store byte-enable helper.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Byte enables for a store of the given width at byte offset off.
   function automatic logic [3:0] be_mask(input logic [2:0] funct3, input logic [1:0] off);
      case (funct3)
         F3_B, F3_BU: return 4'b0001 << off;
         F3_H, F3_HU: return 4'b0011 << off;
         default:     return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Ready/valid data-memory bus.
//   master: drives mem_req/mem_we/mem_addr/mem_wdata/mem_be, samples mem_ready/mem_rdata
//   slave : the memory side
interface load_store_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_be;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/halfword lane of the read word
// selected by the byte offset and sign- or zero-extends it to 32 bits.
//   rdata  : raw word from memory
//   off    : byte offset addr[1:0] of the access
//   funct3 : RV32I load width code
//   data   : extended result
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = off[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'h0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'h0, half_sel};
         default: data = rdata;
      endcase
   end
endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage. Validates a load/store request, runs
// one bus transaction with a timeout, and returns formatted load data while
// holding stall so the PC freezes until the access completes.
//   clk, reset (async, active-low)
//   memread/memwrite/funct3/addr/store_data : request from decode/ALU
//   stall, load_data, load_valid, mem_err    : results to the pipeline
//   bus (master)                             : data-memory bus
//
// state  | meaning
// IDLE   | waiting for a request; illegal requests pulse mem_err here
// ACCESS | bus request outstanding, timeout timer running
// DONE   | access finished; load_valid/mem_err strobe, stall released
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              stall,
   output logic [DATA_W-1:0] load_data,
   output logic              load_valid,
   output logic              mem_err,
   load_store_unit_if.master bus
);
   state_e            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [DATA_W-1:0] load_data_q, load_data_d;
   logic              load_valid_q, load_valid_d;
   logic              mem_err_q, mem_err_d;

   logic              legal;
   logic              stall_raw;
   logic [31:0]       aligned;

   load_align u_align (
      .rdata  (bus.mem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .data   (aligned)
   );

   always_comb begin
      legal = 1'b0;
      if (memread && !memwrite)
         legal = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      else if (memwrite && !memread)
         legal = funct3 inside {F3_B, F3_H, F3_W};
      if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
         legal = 1'b0;
   end

   always_comb begin
      state_d      = state_q;
      off_d        = off_q;
      f3_d         = f3_q;
      cnt_d        = cnt_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      mem_err_d    = 1'b0;
      stall_raw    = 1'b0;

      case (state_q)
         IDLE: begin
            if (memread || memwrite) begin
               if (legal) begin
                  stall_raw   = 1'b1;
                  state_d     = ACCESS;
                  off_d       = addr[1:0];
                  f3_d        = funct3;
                  cnt_d       = 8'(TIMEOUT_CYCLES - 1);
                  mem_req_d   = 1'b1;
                  mem_we_d    = memwrite;
                  mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                  mem_be_d    = memwrite ? be_mask(funct3, addr[1:0]) : 4'b1111;
                  case (funct3[1:0])
                     2'b00:   mem_wdata_d = {4{store_data[7:0]}};
                     2'b01:   mem_wdata_d = {2{store_data[15:0]}};
                     default: mem_wdata_d = store_data;
                  endcase
               end else begin
                  mem_err_d = 1'b1;
               end
            end
         end
         ACCESS: begin
            stall_raw = 1'b1;
            if (bus.mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = DONE;
               if (!mem_we_q) begin
                  load_data_d  = aligned;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_q == 8'd0) begin
               mem_req_d   = 1'b0;
               mem_err_d   = 1'b1;
               load_data_d = '0;
               state_d     = DONE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         off_q        <= '0;
         f3_q         <= '0;
         cnt_q        <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         off_q        <= off_d;
         f3_q         <= f3_d;
         cnt_q        <= cnt_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         mem_err_q    <= mem_err_d;
      end
   end

   // stall is combinational from the request; hold it low while in reset so a
   // request left asserted across reset does not freeze the PC.
   assign stall         = reset & stall_raw;
   assign load_data     = load_data_q;
   assign load_valid    = load_valid_q;
   assign mem_err       = mem_err_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_be    = mem_be_q;
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        memread, memwrite;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        stall, load_valid, mem_err;
   logic [31:0] load_data;
   int          total = 0;
   int          bad = 0;

   load_store_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   load_store_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .memread    (memread),
      .memwrite   (memwrite),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .stall      (stall),
      .load_data  (load_data),
      .load_valid (load_valid),
      .mem_err    (mem_err),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b0; memread = 0; memwrite = 0; funct3 = 0; addr = 0; store_data = 0;
      bus.mem_ready = 0; bus.mem_rdata = 0;
      #3;
      total++;
      if ({bus.mem_req, bus.mem_we, bus.mem_be, stall, load_valid, mem_err} !== 9'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.mem_req, bus.mem_we, bus.mem_be, stall, load_valid, mem_err});
      end
      total++;
      if ({bus.mem_addr, bus.mem_wdata, load_data} !== 96'b0) begin
         bad++; $display("FAIL reset_data addr=%h wdata=%h ld=%h exp=0", bus.mem_addr, bus.mem_wdata, load_data);
      end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_lw();
      @(negedge clk);
      memread = 1; funct3 = 3'b010; addr = 32'h100;
      #1;
      total++;
      if (stall !== 1'b1 || bus.mem_req !== 1'b0) begin
         bad++; $display("FAIL lw_cycle0 stall=%b req=%b exp stall=1 req=0", stall, bus.mem_req);
      end
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h100 || bus.mem_be !== 4'hF || stall !== 1'b1) begin
         bad++; $display("FAIL lw_access req=%b we=%b addr=%h be=%b stall=%b exp 1 0 100 1111 1", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, stall);
      end
      bus.mem_ready = 1; bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      total++;
      if (load_data !== 32'hDEADBEEF || load_valid !== 1'b1 || stall !== 1'b0 || bus.mem_req !== 1'b0 || mem_err !== 1'b0) begin
         bad++; $display("FAIL lw_done ld=%h lv=%b stall=%b req=%b err=%b exp deadbeef 1 0 0 0", load_data, load_valid, stall, bus.mem_req, mem_err);
      end
      memread = 0; bus.mem_ready = 0;
      @(negedge clk);
      total++;
      if (load_valid !== 1'b0 || stall !== 1'b0) begin
         bad++; $display("FAIL lw_idle lv=%b stall=%b exp 0 0", load_valid, stall);
      end
   endtask

   task automatic test_load_ext();
      logic [2:0]  f3v  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] av   [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
      logic [31:0] rdv  [4] = '{32'h80112233, 32'h80112233, 32'h8001AA55, 32'h1234F00F};
      logic [31:0] expv [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00F};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memread = 1; funct3 = f3v[i]; addr = av[i];
         @(negedge clk);
         bus.mem_ready = 1; bus.mem_rdata = rdv[i];
         @(negedge clk);
         total++;
         if (load_data !== expv[i] || load_valid !== 1'b1) begin
            bad++; $display("FAIL load_ext[%0d] ld=%h lv=%b exp=%h lv=1", i, load_data, load_valid, expv[i]);
         end
         memread = 0; bus.mem_ready = 0;
      end
   endtask

   task automatic test_store();
      logic [2:0]  f3v [2] = '{3'b001, 3'b000};
      logic [31:0] av  [2] = '{32'h202, 32'h305};
      logic [31:0] ea  [2] = '{32'h200, 32'h304};
      logic [3:0]  eb  [2] = '{4'b1100, 4'b0010};
      logic [31:0] ew  [2] = '{32'hABCDABCD, 32'hCDCDCDCD};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         memwrite = 1; funct3 = f3v[i]; addr = av[i]; store_data = 32'h1234ABCD;
         @(negedge clk);
         total++;
         if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== ea[i] || bus.mem_be !== eb[i] || bus.mem_wdata !== ew[i]) begin
            bad++; $display("FAIL store[%0d] req=%b we=%b addr=%h be=%b wd=%h exp 1 1 %h %b %h", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, ea[i], eb[i], ew[i]);
         end
         bus.mem_ready = 1;
         @(negedge clk);
         total++;
         if (load_valid !== 1'b0 || stall !== 1'b0 || bus.mem_req !== 1'b0 || mem_err !== 1'b0) begin
            bad++; $display("FAIL store_done[%0d] lv=%b stall=%b req=%b err=%b exp 0 0 0 0", i, load_valid, stall, bus.mem_req, mem_err);
         end
         memwrite = 0; bus.mem_ready = 0;
      end
   endtask

   task automatic test_illegal();
      logic        rdv [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic        wrv [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  f3v [4] = '{3'b010, 3'b000, 3'b100, 3'b101};
      logic [31:0] av  [4] = '{32'h101, 32'h100, 32'h100, 32'h103};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         memread = rdv[i]; memwrite = wrv[i]; funct3 = f3v[i]; addr = av[i];
         #1;
         total++;
         if (stall !== 1'b0) begin
            bad++; $display("FAIL illegal_stall[%0d] got=%b exp=0", i, stall);
         end
         @(negedge clk);
         total++;
         if (mem_err !== 1'b1 || bus.mem_req !== 1'b0 || stall !== 1'b0) begin
            bad++; $display("FAIL illegal_err[%0d] err=%b req=%b stall=%b exp 1 0 0", i, mem_err, bus.mem_req, stall);
         end
         memread = 0; memwrite = 0;
         @(negedge clk);
         total++;
         if (mem_err !== 1'b0 || bus.mem_req !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse[%0d] err=%b req=%b exp 0 0", i, mem_err, bus.mem_req);
         end
      end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      @(negedge clk);
      memread = 1; funct3 = 3'b010; addr = 32'h300; bus.mem_ready = 0;
      @(negedge clk);
      for (int n = 0; n < 40 && bus.mem_req === 1'b1; n++) begin
         req_cycles++;
         @(negedge clk);
      end
      total++;
      if (req_cycles != 16) begin
         bad++; $display("FAIL timeout_len got=%0d exp=16", req_cycles);
      end
      total++;
      if (mem_err !== 1'b1 || load_data !== 32'h0 || load_valid !== 1'b0 || stall !== 1'b0) begin
         bad++; $display("FAIL timeout_done err=%b ld=%h lv=%b stall=%b exp 1 0 0 0", mem_err, load_data, load_valid, stall);
      end
      memread = 0;
      @(negedge clk);
      total++;
      if (mem_err !== 1'b0 || bus.mem_req !== 1'b0) begin
         bad++; $display("FAIL timeout_idle err=%b req=%b exp 0 0", mem_err, bus.mem_req);
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      memread = 1; funct3 = 3'b010; addr = 32'h400; bus.mem_ready = 0;
      repeat (3) @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1 || stall !== 1'b1) begin
         bad++; $display("FAIL rst_pre req=%b stall=%b exp 1 1", bus.mem_req, stall);
      end
      #2 reset = 1'b0;
      #1;
      total++;
      if (bus.mem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0) begin
         bad++; $display("FAIL rst_async req=%b stall=%b err=%b exp 0 0 0", bus.mem_req, stall, mem_err);
      end
      @(negedge clk);
      memread = 0; reset = 1'b1;
      @(negedge clk);
      memwrite = 1; funct3 = 3'b010; addr = 32'h40; store_data = 32'hCAFEF00D;
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_be !== 4'hF || bus.mem_wdata !== 32'hCAFEF00D) begin
         bad++; $display("FAIL rst_sw req=%b we=%b addr=%h be=%b wd=%h exp 1 1 40 1111 cafef00d", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata);
      end
      bus.mem_ready = 1;
      @(negedge clk);
      total++;
      if (bus.mem_req !== 1'b0 || stall !== 1'b0 || mem_err !== 1'b0 || load_valid !== 1'b0) begin
         bad++; $display("FAIL rst_sw_done req=%b stall=%b err=%b lv=%b exp 0 0 0 0", bus.mem_req, stall, mem_err, load_valid);
      end
      memwrite = 0; bus.mem_ready = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_load_ext();
      test_store();
      test_illegal();
      test_timeout();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
